// File: rtl/uart_tx_fifo_if.sv
// Producer-side push handshake for uart_tx_fifo: start/data in, ready (FIFO not full) out.
interface uart_tx_fifo_if #(
    parameter int DATA_BITS = 8
);
    logic                 start;
    logic [DATA_BITS-1:0] arg_send_byte;
    logic                 ready;

    modport master (output start, output arg_send_byte, input ready);
    modport slave  (input start, input arg_send_byte, output ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a small FIFO; queued frames leave back-to-back with no idle gap.
// Define UART_TX_PARITY_EN to add a parity bit (even, or odd when PARITY_ODD=1).
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | line high, waiting for a FIFO entry
// S_START  | start bit (low)
// S_DATA   | data bits, LSB first
// S_PARITY | parity bit (only with UART_TX_PARITY_EN)
// S_STOP   | stop bit(s) high; last cycle pulses finish and may pop the next
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4,
    parameter int PARITY_ODD   = 0
) (
    input  logic                        clk,
    input  logic                        reset,
    uart_tx_fifo_if.slave               tx,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        busy,
    output logic                        finish,
    output logic                        UART_TXD
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BIT_LAST  = BW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);
    localparam logic [CW-1:0] FULL      = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        count_q, count_d;

    state_t               state_q;
    logic [BW-1:0]        bit_cnt_q;
    logic [3:0]           dat_cnt_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 txd_q;
    logic                 busy_q;
    logic                 finish_q;
`ifdef UART_TX_PARITY_EN
    logic                 par_q;
`endif

    logic                 push;
    logic                 pop;
    logic                 bit_end;
    logic [DATA_BITS-1:0] head;

    assign tx.ready = (count_q != FULL);
    assign push     = tx.start && tx.ready;
    assign bit_end  = (bit_cnt_q == BIT_LAST);
    assign head     = mem_q[rd_ptr_q];
    // The next frame is popped either from idle or on the last stop-bit cycle.
    assign pop      = (count_q != '0) &&
                      ((state_q == S_IDLE) ||
                       ((state_q == S_STOP) && bit_end && (dat_cnt_q == STOP_LAST)));

    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        count_d  = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= tx.arg_send_byte;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            bit_cnt_q <= '0;
            dat_cnt_q <= '0;
            shift_q   <= '0;
            txd_q     <= 1'b1;
            busy_q    <= 1'b0;
            finish_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            finish_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (pop) begin
                        shift_q   <= head;
`ifdef UART_TX_PARITY_EN
                        par_q     <= (^head) ^ 1'(PARITY_ODD);
`endif
                        state_q   <= S_START;
                        txd_q     <= 1'b0;
                        busy_q    <= 1'b1;
                        bit_cnt_q <= '0;
                        dat_cnt_q <= '0;
                    end
                end
                S_START: begin
                    if (bit_end) begin
                        bit_cnt_q <= '0;
                        dat_cnt_q <= '0;
                        state_q   <= S_DATA;
                        txd_q     <= shift_q[0];
                    end else begin
                        bit_cnt_q <= bit_cnt_q + BW'(1);
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        bit_cnt_q <= '0;
                        if (dat_cnt_q == DATA_LAST) begin
                            dat_cnt_q <= '0;
`ifdef UART_TX_PARITY_EN
                            state_q   <= S_PARITY;
                            txd_q     <= par_q;
`else
                            state_q   <= S_STOP;
                            txd_q     <= 1'b1;
`endif
                        end else begin
                            dat_cnt_q <= dat_cnt_q + 4'd1;
                            shift_q   <= shift_q >> 1;
                            txd_q     <= shift_q[1];
                        end
                    end else begin
                        bit_cnt_q <= bit_cnt_q + BW'(1);
                    end
                end
`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    if (bit_end) begin
                        bit_cnt_q <= '0;
                        dat_cnt_q <= '0;
                        state_q   <= S_STOP;
                        txd_q     <= 1'b1;
                    end else begin
                        bit_cnt_q <= bit_cnt_q + BW'(1);
                    end
                end
`endif
                S_STOP: begin
                    if (bit_end) begin
                        bit_cnt_q <= '0;
                        if (dat_cnt_q == STOP_LAST) begin
                            finish_q  <= 1'b1;
                            dat_cnt_q <= '0;
                            if (pop) begin
                                shift_q <= head;
`ifdef UART_TX_PARITY_EN
                                par_q   <= (^head) ^ 1'(PARITY_ODD);
`endif
                                state_q <= S_START;
                                txd_q   <= 1'b0;
                            end else begin
                                state_q <= S_IDLE;
                                busy_q  <= 1'b0;
                            end
                        end else begin
                            dat_cnt_q <= dat_cnt_q + 4'd1;
                        end
                    end else begin
                        bit_cnt_q <= bit_cnt_q + BW'(1);
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    txd_q   <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign fifo_count = count_q;
    assign busy       = busy_q;
    assign finish     = finish_q;
    assign UART_TXD   = txd_q;
endmodule
